frame_packer: RTL

FRAME_PACKER -- requirements
Module: frame_packer

---
 rtl/mcs_pkg.sv | 23 ++
 rtl/frame_out_reg.sv | 80 ++++++++
 rtl/frame_packer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mcs_pkg.sv
// Shared types and constants for the frame packer: FSM state encodings,
// counter widths and the saturating increment for the drop counter.
package mcs_pkg;

  localparam int MAX_BYTES_PER_FRAME = 8;
  localparam int TIMER_W             = 8;
  localparam int DROP_CNT_W          = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Single-entry output frame register (EMPTY/HOLD) with drop accounting for
// frames that arrive while a held frame has not been accepted.
module frame_out_reg
  import mcs_pkg::*;
#(
  parameter int BYTES_PER_FRAME = 4
) (
  input  logic                         i_Clock,
  input  logic                         resetn,
  input  logic                         i_Push,
  input  logic [8*BYTES_PER_FRAME-1:0] i_Push_Data,
  input  logic [3:0]                   i_Push_Len,
  input  logic [7:0]                   i_Push_Cksum,
  input  logic                         i_Frame_Ready,
  output logic [8*BYTES_PER_FRAME-1:0] o_Frame_Data,
  output logic [3:0]                   o_Frame_Len,
  output logic [7:0]                   o_Checksum,
  output logic                         o_Frame_Valid,
  output logic                         o_Overflow,
  output logic [DROP_CNT_W-1:0]        o_Drop_Count,
  output logic                         o_State
);

  out_state_t                   r_state;
  logic [8*BYTES_PER_FRAME-1:0] r_data;
  logic [3:0]                   r_len;
  logic [7:0]                   r_cksum;
  logic                         r_overflow;
  logic [DROP_CNT_W-1:0]        r_drop_cnt;
  logic                         w_handshake;

  // Transfer occurs on a rising edge where o_Frame_Valid and i_Frame_Ready are
  // both high; valid never drops and data never changes until that edge.
  assign w_handshake = (r_state == HOLD) && i_Frame_Ready;

  always_ff @(posedge i_Clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= EMPTY;
      r_data     <= '0;
      r_len      <= '0;
      r_cksum    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_Push) begin
            r_data  <= i_Push_Data;
            r_len   <= i_Push_Len;
            r_cksum <= i_Push_Cksum;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (i_Push && w_handshake) begin
            r_data  <= i_Push_Data;
            r_len   <= i_Push_Len;
            r_cksum <= i_Push_Cksum;
          end else if (i_Push) begin
            // Held frame wins; the incoming frame is lost.
            r_overflow <= 1'b1;
            r_drop_cnt <= sat_inc(r_drop_cnt);
          end else if (w_handshake) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_Frame_Data  = r_data;
  assign o_Frame_Len   = r_len;
  assign o_Checksum    = r_cksum;
  assign o_Frame_Valid = (r_state == HOLD);
  assign o_Overflow    = r_overflow;
  assign o_Drop_Count  = r_drop_cnt;
  assign o_State       = r_state;

endmodule

// File: rtl/frame_packer.sv
// Packs an unthrottled byte stream into frames of BYTES_PER_FRAME bytes,
// flushing partial frames after an idle timeout, with a registered output stage.
module frame_packer
  import mcs_pkg::*;
#(
  parameter int BYTES_PER_FRAME = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                         i_Clock,
  input  logic                         resetn,
  input  logic [7:0]                   i_Data,
  input  logic                         i_Data_Valid,
  output logic [8*BYTES_PER_FRAME-1:0] o_Frame_Data,
  output logic [3:0]                   o_Frame_Len,
  output logic [7:0]                   o_Checksum,
  output logic                         o_Frame_Valid,
  input  logic                         i_Frame_Ready,
  output logic                         o_Overflow,
  output logic [7:0]                   o_Drop_Count,
  output logic                         o_Asm_State,
  output logic                         o_Out_State
);

  localparam int CNT_W = $clog2(BYTES_PER_FRAME + 1);
  localparam int FW    = 8 * BYTES_PER_FRAME;

  asm_state_t          r_asm_state;
  logic [CNT_W-1:0]    r_byte_count;
  logic [TIMER_W-1:0]  r_timer;
  logic [FW-1:0]       r_data;
  logic [7:0]          r_xor;
  logic                r_push;
  logic [FW-1:0]       r_push_data;
  logic [3:0]          r_push_len;
  logic [7:0]          r_push_cksum;

  logic [FW-1:0]       w_merged;
  logic                w_last;
  logic                w_timeout;

  always_comb begin
    w_merged = r_data;
    for (int i = 0; i < BYTES_PER_FRAME; i++) begin
      if (r_byte_count == CNT_W'(i)) w_merged[8*i +: 8] = i_Data;
    end
  end

  assign w_last    = (r_byte_count == CNT_W'(BYTES_PER_FRAME - 1));
  assign w_timeout = (r_asm_state == COLLECT) && !i_Data_Valid &&
                     (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Completed or flushed frames go through r_push so that nothing from i_Data
  // reaches the outputs without two register stages.
  always_ff @(posedge i_Clock or negedge resetn) begin
    if (!resetn) begin
      r_asm_state  <= IDLE;
      r_byte_count <= '0;
      r_timer      <= '0;
      r_data       <= '0;
      r_xor        <= '0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_push_len   <= '0;
      r_push_cksum <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_asm_state)
        IDLE: begin
          r_timer <= '0;
          if (i_Data_Valid) begin
            r_data       <= w_merged;
            r_byte_count <= CNT_W'(1);
            r_xor        <= i_Data;
            r_asm_state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (i_Data_Valid) begin
            r_timer <= '0;
            if (w_last) begin
              r_push       <= 1'b1;
              r_push_data  <= w_merged;
              r_push_len   <= 4'(BYTES_PER_FRAME);
              r_push_cksum <= r_xor ^ i_Data;
              r_data       <= '0;
              r_byte_count <= '0;
              r_xor        <= '0;
              r_asm_state  <= IDLE;
            end else begin
              r_data       <= w_merged;
              r_byte_count <= r_byte_count + 1'b1;
              r_xor        <= r_xor ^ i_Data;
            end
          end else if (w_timeout) begin
            // Unused lanes of r_data are still zero from the last clear.
            r_push       <= 1'b1;
            r_push_data  <= r_data;
            r_push_len   <= 4'(r_byte_count);
            r_push_cksum <= r_xor;
            r_data       <= '0;
            r_byte_count <= '0;
            r_xor        <= '0;
            r_timer      <= '0;
            r_asm_state  <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_asm_state <= IDLE;
      endcase
    end
  end

  frame_out_reg #(
    .BYTES_PER_FRAME(BYTES_PER_FRAME)
  ) u_out (
    .i_Clock      (i_Clock),
    .resetn       (resetn),
    .i_Push       (r_push),
    .i_Push_Data  (r_push_data),
    .i_Push_Len   (r_push_len),
    .i_Push_Cksum (r_push_cksum),
    .i_Frame_Ready(i_Frame_Ready),
    .o_Frame_Data (o_Frame_Data),
    .o_Frame_Len  (o_Frame_Len),
    .o_Checksum   (o_Checksum),
    .o_Frame_Valid(o_Frame_Valid),
    .o_Overflow   (o_Overflow),
    .o_Drop_Count (o_Drop_Count),
    .o_State      (o_Out_State)
  );

  assign o_Asm_State = r_asm_state;

endmodule
